// File: rtl/cla_pipe_addsub_if.sv
// Operand/result handshake bundle for cla_pipe_addsub.
// master = producer/consumer side, slave = the adder pipeline.
interface cla_pipe_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor, one WIDTH/STAGES slice per stage.
// Optional macro CLA_SAT_EN: saturate out_sum to the signed limit on overflow.
module cla_pipe_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter int BLOCK  = 4
) (
    input logic              clk,
    input logic              rst,
    cla_pipe_addsub_if.slave bus_io
);
    localparam int SLICE = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    if ((WIDTH % STAGES) != 0 || (SLICE % BLOCK) != 0) begin : gBadParams
        $error("cla_pipe_addsub: WIDTH must split into STAGES slices of whole BLOCK groups");
    end

    // Returns {carry into slice MSB, carry out, sum}; groups ripple, bits look ahead.
    function automatic logic [SLICE+1:0] claSlice(input logic [SLICE-1:0] a,
                                                   input logic [SLICE-1:0] b,
                                                   input logic             cin);
        logic [SLICE-1:0] g;
        logic [SLICE-1:0] p;
        logic [SLICE:0]   c;
        logic             term;
        logic             prod;
        g    = a & b;
        p    = a | b;
        c    = '0;
        c[0] = cin;
        for (int grp = 0; grp < SLICE / BLOCK; grp++) begin
            for (int i = 0; i < BLOCK; i++) begin
                term = c[grp*BLOCK];
                for (int m = 0; m <= i; m++) term = term & p[grp*BLOCK+m];
                for (int j = 0; j <= i; j++) begin
                    prod = g[grp*BLOCK+j];
                    for (int m = j + 1; m <= i; m++) prod = prod & p[grp*BLOCK+m];
                    term = term | prod;
                end
                c[grp*BLOCK+i+1] = term;
            end
        end
        return {c[SLICE-1], c[SLICE], a ^ b ^ c[SLICE-1:0]};
    endfunction

    logic [STAGES-1:0]            valid_q, valid_d;
    logic [STAGES-1:0]            carry_q, carry_d;
    logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d;
    logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
    logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
    logic                         msbCarry_q, msbCarry_d;

    logic                         adv;
    logic                         ovf;
    logic [STAGES-1:0]            vIn;
    logic [STAGES-1:0]            cIn;
    logic [STAGES-1:0][WIDTH-1:0] aIn;
    logic [STAGES-1:0][WIDTH-1:0] bIn;
    logic [STAGES-1:0][WIDTH-1:0] sIn;
    logic [STAGES-1:0][SLICE+1:0] res;

    assign adv             = bus_io.out_ready | ~bus_io.out_valid;
    assign bus_io.in_ready = adv & ~rst;

    // Stage 0 sees the conditioned operands; later stages see the previous stage's registers.
    always_comb begin
        vIn[0] = bus_io.in_valid & bus_io.in_ready;
        aIn[0] = bus_io.in_a;
        bIn[0] = bus_io.in_sub ? ~bus_io.in_b : bus_io.in_b;
        cIn[0] = bus_io.in_sub ? ~bus_io.in_cin : bus_io.in_cin;
        sIn[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            vIn[k] = valid_q[k-1];
            aIn[k] = a_q[k-1];
            bIn[k] = b_q[k-1];
            cIn[k] = carry_q[k-1];
            sIn[k] = sum_q[k-1];
        end
    end

    // Bubbles load zeros so an idle pipeline always presents clean outputs.
    always_comb begin
        valid_d    = valid_q;
        carry_d    = carry_q;
        sum_d      = sum_q;
        a_d        = a_q;
        b_d        = b_q;
        msbCarry_d = msbCarry_q;
        res        = '0;
        for (int k = 0; k < STAGES; k++) begin
            res[k] = claSlice(aIn[k][k*SLICE +: SLICE], bIn[k][k*SLICE +: SLICE], cIn[k]);
        end
        if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_d[k] = vIn[k];
                if (vIn[k]) begin
                    sum_d[k]                  = sIn[k];
                    sum_d[k][k*SLICE +: SLICE] = res[k][SLICE-1:0];
                    carry_d[k]                = res[k][SLICE];
                    a_d[k]                    = aIn[k];
                    b_d[k]                    = bIn[k];
                end else begin
                    sum_d[k]   = '0;
                    carry_d[k] = 1'b0;
                    a_d[k]     = '0;
                    b_d[k]     = '0;
                end
            end
            msbCarry_d = vIn[LAST] ? res[LAST][SLICE+1] : 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            carry_q    <= '0;
            sum_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            msbCarry_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            carry_q    <= carry_d;
            sum_q      <= sum_d;
            a_q        <= a_d;
            b_q        <= b_d;
            msbCarry_q <= msbCarry_d;
        end
    end

    assign ovf              = carry_q[LAST] ^ msbCarry_q;
    assign bus_io.out_valid = valid_q[LAST];
    assign bus_io.out_cout  = carry_q[LAST];
    assign bus_io.out_ovf   = ovf;

`ifdef CLA_SAT_EN
    assign bus_io.out_sum = !ovf ? sum_q[LAST] :
                            a_q[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                               : {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign bus_io.out_sum = sum_q[LAST];
`endif

    // Last-stage operand copies only feed the saturation sign, if at all.
    logic unusedOperands;
    assign unusedOperands = ^{a_q[LAST], b_q[LAST]};
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed bench for cla_pipe_addsub (WIDTH=16, STAGES=2, BLOCK=4).
// Table vectors plus streaming, backpressure and reset sequences checked by a scoreboard.
module tb_cla_pipe_addsub;
    localparam int WIDTH  = 16;
    localparam int STAGES = 2;
    localparam int BLOCK  = 4;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] expSum;
        logic [15:0] expSat;
        logic        expCout;
        logic        expOvf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cla_pipe_addsub_if #(.WIDTH(WIDTH)) bus ();

    cla_pipe_addsub #(
        .WIDTH (WIDTH),
        .STAGES(STAGES),
        .BLOCK (BLOCK)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus.slave)
    );

    int   checks = 0;
    int   errors = 0;
    int   nPopped = 0;
    vec_t expQ[$];
    vec_t curExp;
    vec_t monE;
    vec_t tbl[12];
    logic stallPrev = 1'b0;
    logic [15:0] heldSum;
    logic [1:0]  heldFlags;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [15:0] pickSum(input vec_t v);
`ifdef CLA_SAT_EN
        return v.expSat;
`else
        return v.expSum;
`endif
    endfunction

    // Behavioural reference: plain wide addition, with the bit-15 carry from a 15-bit add.
    function automatic vec_t modelBeat(input logic [15:0] a, input logic [15:0] b,
                                       input logic cin, input logic sub);
        vec_t        v;
        logic [15:0] beff;
        logic        c0;
        logic [16:0] full;
        logic [15:0] low;
        beff      = sub ? ~b : b;
        c0        = sub ? ~cin : cin;
        full      = {1'b0, a} + {1'b0, beff} + {16'd0, c0};
        low       = {1'b0, a[14:0]} + {1'b0, beff[14:0]} + {15'd0, c0};
        v.a       = a;
        v.b       = b;
        v.cin     = cin;
        v.sub     = sub;
        v.expCout = full[16];
        v.expOvf  = full[16] ^ low[15];
        v.expSum  = full[15:0];
        v.expSat  = v.expOvf ? (a[15] ? 16'h8000 : 16'h7FFF) : full[15:0];
        return v;
    endfunction

    // Scoreboard: inputs are stable at the falling edge, so accept/emit are judged there.
    always @(negedge clk) begin
        if (rst) begin
            expQ.delete();
            stallPrev = 1'b0;
        end else begin
            if (stallPrev) begin
                checkOutput("hold sum", {16'd0, bus.out_sum}, {16'd0, heldSum});
                checkOutput("hold flags", {30'd0, bus.out_cout, bus.out_ovf}, {30'd0, heldFlags});
            end
            if (bus.out_valid && !bus.out_ready)
                checkOutput("in_ready while stalled", {31'd0, bus.in_ready}, 32'd0);
            if (bus.out_valid && bus.out_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected output: got sum 0x%0h, expected no beat", bus.out_sum);
                end else begin
                    monE = expQ.pop_front();
                    checkOutput("sum", {16'd0, bus.out_sum}, {16'd0, pickSum(monE)});
                    checkOutput("cout", {31'd0, bus.out_cout}, {31'd0, monE.expCout});
                    checkOutput("ovf", {31'd0, bus.out_ovf}, {31'd0, monE.expOvf});
                    nPopped++;
                end
            end
            if (bus.in_valid && bus.in_ready) expQ.push_back(curExp);
            stallPrev = bus.out_valid && !bus.out_ready;
            heldSum   = bus.out_sum;
            heldFlags = {bus.out_cout, bus.out_ovf};
        end
    end

    // Presents one beat and returns #1 after the edge that accepted it.
    task automatic applyStimulus(input vec_t v, output int cycles);
        logic accepted;
        bus.in_a     = v.a;
        bus.in_b     = v.b;
        bus.in_cin   = v.cin;
        bus.in_sub   = v.sub;
        curExp       = v;
        bus.in_valid = 1'b1;
        accepted     = 1'b0;
        cycles       = 0;
        for (int t = 0; t < 50 && !accepted; t++) begin
            @(negedge clk);
            accepted = bus.in_ready;
            cycles++;
            @(posedge clk);
            #1;
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept timeout: got in_ready 0, expected 1 within 50 cycles");
        end
    endtask

    task automatic waitDrain();
        for (int t = 0; t < 40 && expQ.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("drain", expQ.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 500us");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   cyc;
        int   base;
        vec_t v;

        tbl[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[1]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 16'h0100, 1'b0, 1'b0};
        tbl[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
        tbl[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b1};
        tbl[4]  = '{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFD, 16'hFFFD, 1'b0, 1'b0};
        tbl[5]  = '{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 16'h2346, 1'b0, 1'b0};
        tbl[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 16'h8000, 1'b1, 1'b1};
        tbl[7]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[8]  = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 16'h1000, 1'b0, 1'b0};
        tbl[9]  = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
        tbl[10] = '{16'h5555, 16'hAAAA, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[11] = '{16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0FFE, 16'h0FFE, 1'b1, 1'b0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("reset out_sum", {16'd0, bus.out_sum}, 32'd0);
        checkOutput("reset flags", {30'd0, bus.out_cout, bus.out_ovf}, 32'd0);
        checkOutput("reset in_ready", {31'd0, bus.in_ready}, 32'd0);
        rst = 1'b0;

        $display("[TB] directed vectors");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i], cyc);
            bus.in_valid = 1'b0;
            checkOutput("latency early", {31'd0, bus.out_valid}, 32'd0);
            @(posedge clk);
            #1;
            checkOutput("latency due", {31'd0, bus.out_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        waitDrain();

        $display("[TB] back-to-back stream");
        base = nPopped;
        for (int i = 0; i < 8; i++) begin
            v = modelBeat(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            applyStimulus(v, cyc);
            checkOutput("stream accept cycles", cyc, 32'd1);
        end
        bus.in_valid = 1'b0;
        waitDrain();
        checkOutput("stream count", nPopped - base, 32'd8);

        $display("[TB] backpressure");
        base = nPopped;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    v = modelBeat(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
                    applyStimulus(v, cyc);
                end
                bus.in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        waitDrain();
        checkOutput("backpressure count", nPopped - base, 32'd10);

        $display("[TB] reset with beats in flight");
        applyStimulus(tbl[5], cyc);
        applyStimulus(tbl[8], cyc);
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        #1;
        checkOutput("in_ready in reset", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("post-reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("post-reset out_sum", {16'd0, bus.out_sum}, 32'd0);
        checkOutput("post-reset flags", {30'd0, bus.out_cout, bus.out_ovf}, 32'd0);
        base = nPopped;
        v    = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 16'h2345, 1'b0, 1'b0};
        applyStimulus(v, cyc);
        bus.in_valid = 1'b0;
        checkOutput("first accept after reset", cyc, 32'd1);
        waitDrain();
        checkOutput("post-reset count", nPopped - base, 32'd1);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/cla_pipe_addsub.md
Name: cla_pipe_addsub

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready handshake on both sides.
- The WIDTH-bit operation is split into STAGES equal slices, one per pipeline stage.
- Each slice uses BLOCK-bit lookahead groups whose group carries ripple within the slice.
- The carry is registered between stages. Operand slices are skewed so that one operation per cycle is accepted.
- Used as the wide datapath adder wherever a single-cycle ripple or lookahead chain would not close timing.

Parameters:
WIDTH, 16, operand/result width in bits
STAGES, 2, pipeline stages; latency in cycles; WIDTH % STAGES == 0 required
BLOCK, 4, lookahead group size in bits; (WIDTH/STAGES) % BLOCK == 0 required

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts beat this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_cin  input  1  carry-in (add) / borrow-in (sub)
in_sub  input  1  0 = A+B+cin, 1 = A-B-cin
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_sum  output  WIDTH  result
out_cout  output  1  raw carry out of MSB (sub: 1 = no borrow)
out_ovf  output  1  signed (two's complement) overflow

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Elaboration: an illegal parameter combination raises $error.
- Operand conditioning at acceptance:
  - b_eff = in_sub ? ~in_b : in_b
  - c0 = in_sub ? ~in_cin : in_cin
- Slice definition: SLICE = WIDTH/STAGES. Stage k (0-based) computes bits [k*SLICE +: SLICE].
  - Stage k's carry-in is c0 when k = 0, otherwise the carry register of stage k-1.
- Lookahead: within a slice, each BLOCK group computes:
  - generate g = a&b and propagate p = a|b per bit
  - group G/P, and in-group carries c[i+1] = g[i] | p[i]&c[i] expanded to lookahead form
  - sum bit = a ^ b ^ c
- Pipeline advance: the whole pipeline advances when adv = out_ready | ~out_valid.
  - in_ready = adv & ~rst.
  - A beat is accepted when in_valid & in_ready.
- Per-stage registers: valid bit, computed sum slices so far, carry out, unconsumed operand slices, and the carry into the MSB (last stage only).
  - Stages advance only on adv. On stall, all stage registers hold.
- Latency: a beat accepted at edge n appears on out_* after edge n+STAGES-1, visible from cycle n+STAGES when not stalled. Throughput is 1 beat/cycle.
- Bubbles: an empty stage propagates valid = 0. Bubbles collapse only through adv (a global stall, not elastic per stage).
- Output flags:
  - out_cout = carry out of bit WIDTH-1
  - out_ovf = carry into MSB XOR carry out of MSB
- Output stability: while out_valid & ~out_ready, out_sum/out_cout/out_ovf stay stable.
- Reset values: all valid bits 0, all data/carry registers 0, so out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0. in_ready = 0 while rst is high.
- Reset mid-operation: all in-flight beats are discarded, with no partial output. The first accept is possible the cycle after rst falls.
- Simultaneous accept and emit on one edge is legal; no beat is lost or duplicated.
- Beat order is preserved.
- Wrap-around: results are modulo 2^WIDTH; flags report the wrap.

Optional Feature:
CLA_SAT_EN:
- Defined: when a result's ovf = 1, out_sum is replaced by the signed saturation value. That is 0x7F..F if the operand A sign bit is 0, and 0x80..0 if it is 1.
  - out_ovf is still asserted.
  - out_cout is unchanged.
  - No extra latency; the substitution is in the final stage.
- Undefined: out_sum is always the raw wrapped result.

Test Plan:
(WIDTH=16, STAGES=2, BLOCK=4, out_ready=1 unless noted)
1. Add 0xFFFF + 0x0001, cin=0 -> out_sum=0x0000, out_cout=1, out_ovf=0; out_valid rises 2 cycles after acceptance.
2. Cross-slice carry: add 0x00FF + 0x0001 -> 0x0100, cout=0. Add 0x7FFF + 0x0001 -> 0x8000, ovf=1 (0x7FFF with CLA_SAT_EN).
3. Sub 0x8000 - 0x0001, cin=0 -> 0x7FFF, cout=1, ovf=1 (0x8000 with CLA_SAT_EN). Sub 0x0003 - 0x0005, cin=1 -> 0xFFFD, cout=0, ovf=0.
4. Stream 8 back-to-back random beats -> 8 results on consecutive cycles, in order, each matching the reference model.
5. Backpressure: stream beats, drop out_ready for 4 cycles -> in_ready=0 when the pipeline is full, outputs held stable, no loss or duplication once out_ready returns.
6. Reset with 2 beats in flight -> out_valid=0 and all outputs 0 the cycle after rst; a new beat 0x1234+0x1111 after reset yields 0x2345.
